div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sits in the EX stage directly upstream of the iterative Divider.
- Accepts RV64M divide ops: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- Resolves the architectural special cases locally: divide-by-zero and signed overflow.
- Prepares operands and drives the Divider handshake, then returns the architecturally correct 64-bit result to writeback through a valid/ready port.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept an op
- in_op  in  2  bit0 = unsigned, bit1 = remainder (funct3[1:0] of the RV M divide ops)
- in_is_w  in  1  32-bit W variant
- in_rs1  in  64  dividend
- in_rs2  in  64  divisor
- flush  in  1  pipeline flush; aborts any in-flight op
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- out_data  out  64  result
- div_dividend  out  64  to Divider io_i_dividend
- div_divisor  out  64  to Divider io_i_divisor
- div_valid  out  1  to Divider io_i_div_valid
- div_divw  out  1  to Divider io_i_divw
- div_signed  out  1  to Divider io_i_div_signed
- div_flush  out  1  to Divider io_i_flush
- div_in_ready  in  1  from Divider io_o_out_ready (Divider can accept)
- div_done  in  1  from Divider io_o_out_valid
- div_quotient  in  64  from Divider io_o_quotient
- div_remainder  in  64  from Divider io_o_remainder

Behaviour:
- Reset values: all outputs and state registers are 0; state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- in_ready is 1 only in IDLE. An op is accepted when in_valid && in_ready; on acceptance, latch op, is_w and the prepared operands.
- Operand prep:
  - For W ops, take bits [31:0] of each operand and extend to 64 bits: sign-extend if signed, zero-extend if unsigned.
  - div_divw = is_w.
  - div_signed = ~op[0].
- Special-case detection, evaluated on the prepared operands at acceptance:
  - Zero divisor: test divisor[31:0] for W ops, the full divisor otherwise. Quotient = all-ones; remainder = dividend.
  - Signed overflow: signed op, dividend equals the most-negative value for the op width, divisor = -1. Quotient = dividend; remainder = 0.
  - On a special case, skip the Divider. Go IDLE -> DONE with the result registered. out_valid rises the cycle after acceptance.
- Normal path:
  - IDLE -> ISSUE.
  - In ISSUE, div_valid = 1 with stable operands until div_in_ready = 1 is sampled; then go to WAIT.
  - In WAIT, div_valid = 0. When div_done = 1, capture the result and go to DONE.
- Result select: quotient if op[1] = 0, else remainder. For W ops, out_data = sign-extension of the selected value's bits [31:0], for both signed and unsigned variants.
- DONE: out_valid = 1 and out_data is held stable until out_ready = 1. Then return to IDLE; in_ready becomes 1 in the next cycle, so there are no back-to-back bubbles beyond that one cycle.
- flush:
  - In any state, return to IDLE next cycle and drop out_valid; no result is produced.
  - If flush arrives in ISSUE or WAIT, pulse div_flush for exactly one cycle.
  - flush has priority over in_valid, div_done and out_ready in the same cycle. An op presented together with flush is not accepted.
- div_done outside WAIT is ignored.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0. The Divider is reset by the same reset.

Decomposition:
- Shared package holds the op-field bit positions (UNSIGNED_BIT = 0, REM_BIT = 1), the FSM state encoding, and the XLEN constant.
- One sub-module, div_special_case: a combinational detector for the zero-divisor and overflow cases that also produces the special-case result. It is reusable by the multiplier-side bypass.

Test Plan:
- DIV, rs1 = -7, rs2 = 2, Divider model returns after 33 cycles -> out_data = -3, one div_valid accept observed. REM on the same operands -> out_data = -1.
- DIVU, rs2 = 0, rs1 = 0x1234 -> out_valid the cycle after acceptance, out_data = 0xFFFF_FFFF_FFFF_FFFF, div_valid never asserted. REMU on the same operands -> out_data = 0x1234.
- DIV, rs1 = 0x8000_0000_0000_0000, rs2 = -1 -> out_data = 0x8000_0000_0000_0000, no Divider use. REMW with rs1[31:0] = 0x8000_0000, rs2 = -1 -> out_data = 0.
- DIVUW, rs1 = 0xFFFF_FFFF_FFFF_FFFE, rs2 = 1 -> div_dividend = 0x0000_0000_FFFF_FFFE, div_divw = 1, out_data = 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- div_in_ready held low for 5 cycles in ISSUE -> div_valid and operands stable throughout. Then out_ready held low for 3 cycles in DONE -> out_data stable and in_ready = 0.
- flush asserted while in WAIT -> div_flush high for one cycle, IDLE next cycle, a later div_done is ignored, no out_valid. A random 10k-op regression against a reference model passes.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants, types and operand/result helpers for the divide issue controller.
package div_issue_ctrl_pkg;

   localparam int XLEN = 64;

   // Field positions within funct3[1:0] of the RV M divide ops
   localparam int UNSIGNED_BIT = 0;
   localparam int REM_BIT      = 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef logic [XLEN-1:0] xlen_t;

   typedef struct packed {
      logic div_by_zero;
      logic overflow;
   } special_t;

   // W ops divide the low word, extended according to signedness
   function automatic xlen_t prep_operand(input xlen_t value, input logic is_w,
                                          input logic is_signed);
      if (!is_w) return value;
      return is_signed ? {{(XLEN-32){value[31]}}, value[31:0]}
                       : {{(XLEN-32){1'b0}}, value[31:0]};
   endfunction

   // W results are always sign-extended, even for the unsigned variants
   function automatic xlen_t format_result(input xlen_t value, input logic is_w);
      return is_w ? {{(XLEN-32){value[31]}}, value[31:0]} : value;
   endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Upstream, writeback and Divider-side signals of the divide issue controller.
interface div_issue_ctrl_if;
   import div_issue_ctrl_pkg::*;

   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic       in_is_w;
   xlen_t      in_rs1;
   xlen_t      in_rs2;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   xlen_t      out_data;
   xlen_t      div_dividend;
   xlen_t      div_divisor;
   logic       div_valid;
   logic       div_divw;
   logic       div_signed;
   logic       div_flush;
   logic       div_in_ready;
   logic       div_done;
   xlen_t      div_quotient;
   xlen_t      div_remainder;

   modport slave (
      input  in_valid, in_op, in_is_w, in_rs1, in_rs2, flush, out_ready,
             div_in_ready, div_done, div_quotient, div_remainder,
      output in_ready, out_valid, out_data, div_dividend, div_divisor,
             div_valid, div_divw, div_signed, div_flush
   );

   modport master (
      output in_valid, in_op, in_is_w, in_rs1, in_rs2, flush, out_ready,
             div_in_ready, div_done, div_quotient, div_remainder,
      input  in_ready, out_valid, out_data, div_dividend, div_divisor,
             div_valid, div_divw, div_signed, div_flush
   );

endinterface

// File: rtl/div_special_case.sv
// Combinational detector for divide-by-zero and signed overflow, producing the
// architectural result directly so the iterative unit can be bypassed.
module div_special_case
   import div_issue_ctrl_pkg::*;
(
   input  xlen_t    dividend,
   input  xlen_t    divisor,
   input  logic     is_w,
   input  logic     is_signed,
   input  logic     want_rem,
   output special_t kind,
   output xlen_t    result
);

   localparam xlen_t MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic zero_div;
   logic min_dividend;
   logic neg_one_div;

   always_comb begin
      zero_div     = is_w ? (divisor[31:0] == '0) : (divisor == '0);
      min_dividend = is_w ? (dividend[31:0] == 32'h8000_0000) : (dividend == MOST_NEG);
      neg_one_div  = is_w ? (divisor[31:0] == '1) : (divisor == '1);

      kind.div_by_zero = zero_div;
      kind.overflow    = is_signed && min_dividend && neg_one_div;

      if (kind.div_by_zero) begin
         result = want_rem ? dividend : '1;
      end else if (kind.overflow) begin
         result = want_rem ? '0 : dividend;
      end else begin
         result = '0;
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage front end of the iterative Divider: operand prep, special-case bypass,
// Divider handshake and result formatting for the RV64M divide ops.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
(
   input logic             clock,
   input logic             reset,
   div_issue_ctrl_if.slave bus
);

   logic [1:0] state_q, state_d;
   logic       rem_q, rem_d;
   logic       signed_q, signed_d;
   logic       is_w_q, is_w_d;
   xlen_t      dividend_q, dividend_d;
   xlen_t      divisor_q, divisor_d;
   xlen_t      result_q, result_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       div_valid_q, div_valid_d;
   logic       div_flush_q, div_flush_d;

   logic       in_signed;
   xlen_t      in_dividend;
   xlen_t      in_divisor;
   special_t   sc_kind;
   xlen_t      sc_result;
   logic       accept;

   assign in_signed   = ~bus.in_op[UNSIGNED_BIT];
   assign in_dividend = prep_operand(bus.in_rs1, bus.in_is_w, in_signed);
   assign in_divisor  = prep_operand(bus.in_rs2, bus.in_is_w, in_signed);
   assign accept      = bus.in_valid && in_ready_q && !bus.flush;

   div_special_case u_special (
      .dividend  (in_dividend),
      .divisor   (in_divisor),
      .is_w      (bus.in_is_w),
      .is_signed (in_signed),
      .want_rem  (bus.in_op[REM_BIT]),
      .kind      (sc_kind),
      .result    (sc_result)
   );

   always_comb begin
      // NOTE: every _d takes its _q value first, so no path through the case leaves a latch.
      state_d     = state_q;
      rem_d       = rem_q;
      signed_d    = signed_q;
      is_w_d      = is_w_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      result_d    = result_q;
      div_flush_d = 1'b0;

      if (bus.flush) begin
         state_d     = ST_IDLE;
         div_flush_d = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  rem_d      = bus.in_op[REM_BIT];
                  signed_d   = in_signed;
                  is_w_d     = bus.in_is_w;
                  dividend_d = in_dividend;
                  divisor_d  = in_divisor;
                  if (|sc_kind) begin
                     result_d = format_result(sc_result, bus.in_is_w);
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: if (bus.div_in_ready) state_d = ST_WAIT;
            ST_WAIT: begin
               if (bus.div_done) begin
                  result_d = format_result(rem_q ? bus.div_remainder : bus.div_quotient, is_w_q);
                  state_d  = ST_DONE;
               end
            end
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      // Status outputs are registered from the next state so they read 0 under reset
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      div_valid_d = (state_d == ST_ISSUE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rem_q       <= 1'b0;
         signed_q    <= 1'b0;
         is_w_q      <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         div_valid_q <= 1'b0;
         div_flush_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
         state_q     <= state_d;
         rem_q       <= rem_d;
         signed_q    <= signed_d;
         is_w_q      <= is_w_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         div_valid_q <= div_valid_d;
         div_flush_q <= div_flush_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = result_q;
   assign bus.div_dividend = dividend_q;
   assign bus.div_divisor  = divisor_q;
   assign bus.div_valid    = div_valid_q;
   assign bus.div_divw     = is_w_q;
   assign bus.div_signed   = signed_q;
   assign bus.div_flush    = div_flush_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: directed corner cases plus a randomized
// regression against an architectural RV64M divide model, with a Divider model.
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   typedef struct {
      logic [63:0] data;
      string       name;
   } exp_t;

   logic clock;
   logic reset;

   div_issue_ctrl_if bus();

   div_issue_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int   n_cmp;
   int   n_fail;
   exp_t exp_q[$];
   int   dv_cycles;
   int   ov_cycles;
   int   div_accepts;
   int   div_dones;
   int   div_latency;
   logic rdy_allow;
   logic ignore_flush;
   logic rand_mode;
   logic busy;
   int   lat_cnt;
   logic [63:0] q_pend;
   logic [63:0] r_pend;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Architectural RV64M divide semantics
   function automatic logic [63:0] ref_div(input logic [1:0] op, input logic is_w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [31:0] q32, r32, sel32;
      logic [63:0] q, r;
      if (is_w) begin
         if (b[31:0] == 32'd0) begin
            q32 = '1; r32 = a[31:0];
         end else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
            q32 = a[31:0]; r32 = '0;
         end else if (op[0]) begin
            q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
         end else begin
            q32 = 32'($signed(a[31:0]) / $signed(b[31:0]));
            r32 = 32'($signed(a[31:0]) % $signed(b[31:0]));
         end
         sel32 = op[1] ? r32 : q32;
         return {{32{sel32[31]}}, sel32};
      end
      if (b == 64'd0) begin
         q = '1; r = a;
      end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
         q = a; r = '0;
      end else if (op[0]) begin
         q = a / b; r = a % b;
      end else begin
         q = 64'($signed(a) / $signed(b));
         r = 64'($signed(a) % $signed(b));
      end
      return op[1] ? r : q;
   endfunction

   // Raw iterative-divider behaviour on already-prepared 64-bit operands
   function automatic logic [127:0] model_div(input logic [63:0] a, input logic [63:0] b,
                                              input logic sgn);
      if (b == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
      if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return {a, 64'd0};
      if (sgn) return {64'($signed(a) / $signed(b)), 64'($signed(a) % $signed(b))};
      return {a / b, a % b};
   endfunction

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return {$urandom, 32'h8000_0000};
         4:       return 64'($urandom_range(1, 20));
         5:       return -64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   assign bus.div_in_ready = rdy_allow & ~busy;

   // Divider model: accepts on div_valid && ready, answers after div_latency cycles
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         busy              <= 1'b0;
         lat_cnt           <= 0;
         div_accepts       <= 0;
         div_dones         <= 0;
         bus.div_done      <= 1'b0;
         bus.div_quotient  <= '0;
         bus.div_remainder <= '0;
      end else begin
         bus.div_done <= 1'b0;
         if (bus.div_flush && !ignore_flush) begin
            busy <= 1'b0;
         end else if (busy) begin
            if (lat_cnt == 0) begin
               busy              <= 1'b0;
               bus.div_done      <= 1'b1;
               bus.div_quotient  <= q_pend;
               bus.div_remainder <= r_pend;
               div_dones         <= div_dones + 1;
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end else if (bus.div_valid && bus.div_in_ready) begin
            busy               <= 1'b1;
            lat_cnt            <= div_latency - 1;
            div_accepts        <= div_accepts + 1;
            {q_pend, r_pend}   <= model_div(bus.div_dividend, bus.div_divisor, bus.div_signed);
         end
      end
   end

   // Monitor: pops the scoreboard on every writeback handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (bus.div_valid) dv_cycles++;
            if (bus.out_valid) ov_cycles++;
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_result: got %h with no result outstanding", bus.out_data);
               end else begin
                  e = exp_q.pop_front();
                  check(e.name, bus.out_data, e.data);
               end
            end
         end
      end
   end

   // Random back-pressure on both handshakes during the regression
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_mode) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rdy_allow     = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic send_op(input logic [1:0] op, input logic is_w, input logic [63:0] rs1,
                          input logic [63:0] rs2, input logic [63:0] expv, input string name);
      int   budget;
      logic taken;
      budget = 0;
      taken  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_is_w  = is_w;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      while (!taken && budget < 400) begin
         @(negedge clock);
         if (bus.in_ready && !bus.flush) taken = 1'b1;
         else budget++;
      end
      if (taken) exp_q.push_back('{expv, name});
      else check({name, "_accept_timeout"}, 64'd0, 64'd1);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      @(negedge clock);
      while (!bus.out_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
   endtask

   initial begin
      int acc0, dv0, ov0, d0;
      n_cmp = 0; n_fail = 0; dv_cycles = 0; ov_cycles = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_is_w = 1'b0;
      bus.in_rs1 = '0; bus.in_rs2 = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      rdy_allow = 1'b1; ignore_flush = 1'b0; rand_mode = 1'b0; div_latency = 1;

      @(negedge clock);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      check("rst_div_valid", 64'(bus.div_valid), 64'd0);
      check("rst_div_signed", 64'(bus.div_signed), 64'd0);
      check("rst_div_flush", 64'(bus.div_flush), 64'd0);
      check("rst_div_dividend", bus.div_dividend, 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clock);
      #1;

      // DIV / REM of -7 by 2 through a slow Divider
      div_latency = 33;
      acc0 = div_accepts;
      send_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
      wait_idle("div_m7_2");
      check("div_m7_2_accepts", 64'(div_accepts - acc0), 64'd1);
      send_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
      wait_idle("rem_m7_2");
      div_latency = 2;

      // Divide by zero bypasses the Divider
      dv0 = dv_cycles;
      send_op(2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by_zero");
      @(negedge clock);
      check("divu_zero_valid_next_cycle", 64'(bus.out_valid), 64'd1);
      wait_idle("divu_by_zero");
      send_op(2'b11, 1'b0, 64'h1234, 64'd0, 64'h1234, "remu_by_zero");
      wait_idle("remu_by_zero");
      check("by_zero_no_div_valid", 64'(dv_cycles - dv0), 64'd0);

      // Signed overflow, 64-bit and W
      acc0 = div_accepts;
      send_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div_overflow");
      wait_idle("div_overflow");
      send_op(2'b10, 1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, "remw_overflow");
      wait_idle("remw_overflow");
      check("overflow_no_divider", 64'(div_accepts - acc0), 64'd0);

      // DIVUW zero-extends its operands and sign-extends its result
      send_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, "divuw");
      @(negedge clock);
      check("divuw_div_valid", 64'(bus.div_valid), 64'd1);
      check("divuw_dividend", bus.div_dividend, 64'h0000_0000_FFFF_FFFE);
      check("divuw_divisor", bus.div_divisor, 64'd1);
      check("divuw_divw", 64'(bus.div_divw), 64'd1);
      check("divuw_signed", 64'(bus.div_signed), 64'd0);
      wait_idle("divuw");

      // Divider stall in ISSUE, then writeback stall in DONE
      rdy_allow = 1'b0;
      send_op(2'b00, 1'b0, 64'd100, 64'd7, 64'd14, "stall_div");
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_div_valid", 64'(bus.div_valid), 64'd1);
         check("stall_dividend", bus.div_dividend, 64'd100);
         check("stall_divisor", bus.div_divisor, 64'd7);
      end
      @(posedge clock);
      #1;
      rdy_allow = 1'b1;
      bus.out_ready = 1'b0;
      wait_out_valid("stall_done");
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", 64'(bus.out_valid), 64'd1);
         check("hold_out_data", bus.out_data, 64'd14);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1 bus.out_ready = 1'b1;
      wait_idle("stall_div");

      // Flush in WAIT; the late div_done must be ignored
      div_latency = 10;
      ignore_flush = 1'b1;
      d0 = div_dones;
      send_op(2'b00, 1'b0, 64'd50, 64'd5, 64'd10, "flush_wait_op");
      @(posedge clock);
      #1;
      @(negedge clock);
      check("wait_div_valid_low", 64'(bus.div_valid), 64'd0);
      @(posedge clock);
      #1 bus.flush = 1'b1;
      @(posedge clock);
      #1 bus.flush = 1'b0;
      void'(exp_q.pop_back());
      ov0 = ov_cycles;
      @(negedge clock);
      check("flush_div_flush_pulse", 64'(bus.div_flush), 64'd1);
      check("flush_idle_next", 64'(bus.in_ready), 64'd1);
      @(negedge clock);
      check("flush_div_flush_one_cycle", 64'(bus.div_flush), 64'd0);
      repeat (12) @(negedge clock);
      check("flush_late_done_seen", 64'(div_dones - d0), 64'd1);
      check("flush_no_out_valid", 64'(ov_cycles - ov0), 64'd0);
      check("flush_in_ready_kept", 64'(bus.in_ready), 64'd1);
      ignore_flush = 1'b0;
      div_latency = 2;
      @(posedge clock);
      #1;

      // An op presented together with flush is not accepted
      bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_is_w = 1'b0;
      bus.in_rs1 = 64'd9; bus.in_rs2 = 64'd0; bus.flush = 1'b1;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      @(negedge clock);
      check("flush_blocks_accept_ready", 64'(bus.in_ready), 64'd1);
      check("flush_blocks_accept_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_blocks_accept_div_valid", 64'(bus.div_valid), 64'd0);
      @(posedge clock);
      #1;

      // Flush in DONE drops the result without a div_flush pulse
      bus.out_ready = 1'b0;
      send_op(2'b01, 1'b0, 64'd3, 64'd0, '1, "flush_done_op");
      @(negedge clock);
      check("flush_done_pre_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clock);
      #1 bus.flush = 1'b1;
      @(posedge clock);
      #1 bus.flush = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clock);
      check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_done_no_div_flush", 64'(bus.div_flush), 64'd0);
      check("flush_done_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clock);
      #1 bus.out_ready = 1'b1;

      // Randomized regression against the architectural model
      rand_mode = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         logic [1:0]  op;
         logic        w;
         logic [63:0] a, b;
         op = 2'($urandom);
         w  = 1'($urandom);
         a  = rand_operand();
         b  = rand_operand();
         div_latency = $urandom_range(1, 3);
         send_op(op, w, a, b, ref_div(op, w, a, b), $sformatf("rand%0d", i));
      end
      rand_mode = 1'b0;
      @(posedge clock);
      #1;
      bus.out_ready = 1'b1;
      rdy_allow = 1'b1;
      wait_idle("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
